// File: rtl/control_pipe_if.sv
// rtl/control_pipe_if.sv - decode inputs and per-stage control outputs of control_pipe
// master drives the decode-stage inputs; slave is the control pipeline itself.
interface control_pipe_if #(
   parameter int REG_AW    = 5,
   parameter int ALUCTRL_W = 3
);
   logic [31:0]          instr_d;
   logic                 valid_d;
   logic                 flush_e;
   logic                 stall_ext;
   logic [2:0]           imm_src_d;
   logic                 hazard_stall_d;
   logic                 illegal_d;
   logic [ALUCTRL_W-1:0] alu_ctrl_e;
   logic                 alu_src_e;
   logic [2:0]           branch_type_e;
   logic [1:0]           jump_type_e;
   logic [REG_AW-1:0]    rs1_e;
   logic [REG_AW-1:0]    rs2_e;
   logic [REG_AW-1:0]    rd_e;
   logic [1:0]           fwd_a_e;
   logic [1:0]           fwd_b_e;
   logic                 reg_write_m;
   logic                 mem_write_m;
   logic                 byte_addr_m;
   logic [1:0]           result_src_m;
   logic [REG_AW-1:0]    rd_m;
   logic                 reg_write_w;
   logic [1:0]           result_src_w;
   logic [REG_AW-1:0]    rd_w;

   modport master (
      output instr_d, valid_d, flush_e, stall_ext,
      input  imm_src_d, hazard_stall_d, illegal_d,
      input  alu_ctrl_e, alu_src_e, branch_type_e, jump_type_e,
      input  rs1_e, rs2_e, rd_e, fwd_a_e, fwd_b_e,
      input  reg_write_m, mem_write_m, byte_addr_m, result_src_m, rd_m,
      input  reg_write_w, result_src_w, rd_w
   );

   modport slave (
      input  instr_d, valid_d, flush_e, stall_ext,
      output imm_src_d, hazard_stall_d, illegal_d,
      output alu_ctrl_e, alu_src_e, branch_type_e, jump_type_e,
      output rs1_e, rs2_e, rd_e, fwd_a_e, fwd_b_e,
      output reg_write_m, mem_write_m, byte_addr_m, result_src_m, rd_m,
      output reg_write_w, result_src_w, rd_w
   );
endinterface

// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - RV32 subset decode with D/E/M/W control pipeline, load-use and forwarding
// Optional macro CONTROL_PIPE_BRANCH_EXT_EN adds blt/bge/bltu/bgeu decode.
module control_pipe #(
   parameter int REG_AW    = 5,
   parameter int ALUCTRL_W = 3
) (
   input logic           clk,
   input logic           rst,
   control_pipe_if.slave pif
);

   localparam logic [ALUCTRL_W-1:0] alu_add = ALUCTRL_W'(3'b000);
   localparam logic [ALUCTRL_W-1:0] alu_sub = ALUCTRL_W'(3'b001);
   localparam logic [ALUCTRL_W-1:0] alu_and = ALUCTRL_W'(3'b010);
   localparam logic [ALUCTRL_W-1:0] alu_xor = ALUCTRL_W'(3'b100);

   typedef struct packed {
      logic [ALUCTRL_W-1:0] alu_ctrl;
      logic                 alu_src;
      logic [2:0]           branch_type;
      logic [1:0]           jump_type;
      logic                 reg_write;
      logic                 mem_write;
      logic                 byte_addr;
      logic [1:0]           result_src;
      logic [REG_AW-1:0]    rs1;
      logic [REG_AW-1:0]    rs2;
      logic [REG_AW-1:0]    rd;
   } ctl_t;

   ctl_t              dec;
   ctl_t              e_q;
   logic [2:0]        imm_src;
   logic              legal;
   logic              use1;
   logic              use2;
   logic              hazard_raw;
   logic [REG_AW-1:0] rs1_d;
   logic [REG_AW-1:0] rs2_d;
   logic [6:0]        opcode;
   logic [2:0]        f3;
   logic [6:0]        f7;

   logic              reg_write_m_q, mem_write_m_q, byte_addr_m_q;
   logic [1:0]        result_src_m_q;
   logic [REG_AW-1:0] rd_m_q;
   logic              reg_write_w_q;
   logic [1:0]        result_src_w_q;
   logic [REG_AW-1:0] rd_w_q;

   assign opcode = pif.instr_d[6:0];
   assign f3     = pif.instr_d[14:12];
   assign f7     = pif.instr_d[31:25];
   assign rs1_d  = REG_AW'(pif.instr_d[19:15]);
   assign rs2_d  = REG_AW'(pif.instr_d[24:20]);

   always_comb begin
      dec     = '0;
      imm_src = 3'b000;
      legal   = 1'b0;
      use1    = 1'b0;
      use2    = 1'b0;
      case (opcode)
         7'b0110011: begin
            legal         = 1'b1;
            use1          = 1'b1;
            use2          = 1'b1;
            dec.reg_write = 1'b1;
            case ({f7, f3})
               {7'h00, 3'b000}: dec.alu_ctrl = alu_add;
               {7'h20, 3'b000}: dec.alu_ctrl = alu_sub;
               {7'h00, 3'b100}: dec.alu_ctrl = alu_xor;
               {7'h00, 3'b111}: dec.alu_ctrl = alu_and;
               default:         legal = 1'b0;
            endcase
         end
         7'b0010011: begin
            legal         = (f3 == 3'b000);
            use1          = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_ctrl  = alu_add;
         end
         7'b1100011: begin
            legal        = 1'b1;
            use1         = 1'b1;
            use2         = 1'b1;
            imm_src      = 3'b010;
            dec.alu_ctrl = alu_sub;
            case (f3)
               3'b000:  dec.branch_type = 3'b001;
               3'b001:  dec.branch_type = 3'b010;
`ifdef CONTROL_PIPE_BRANCH_EXT_EN
               3'b100:  dec.branch_type = 3'b011;
               3'b101:  dec.branch_type = 3'b100;
               3'b110:  dec.branch_type = 3'b101;
               3'b111:  dec.branch_type = 3'b110;
`endif
               default: legal = 1'b0;
            endcase
         end
         7'b1101111: begin
            legal          = 1'b1;
            imm_src        = 3'b011;
            dec.jump_type  = 2'b01;
            dec.reg_write  = 1'b1;
            dec.result_src = 2'b10;
         end
         7'b1100111: begin
            legal          = (f3 == 3'b000);
            use1           = 1'b1;
            dec.jump_type  = 2'b10;
            dec.reg_write  = 1'b1;
            dec.result_src = 2'b10;
            dec.alu_src    = 1'b1;
            dec.alu_ctrl   = alu_add;
         end
         7'b0110111: begin
            legal          = 1'b1;
            imm_src        = 3'b100;
            dec.reg_write  = 1'b1;
            dec.result_src = 2'b11;
         end
         7'b0100011: begin
            legal         = (f3 == 3'b000);
            use1          = 1'b1;
            use2          = 1'b1;
            imm_src       = 3'b001;
            dec.mem_write = 1'b1;
            dec.byte_addr = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_ctrl  = alu_add;
         end
         7'b0000011: begin
            legal          = (f3 == 3'b100);
            use1           = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = 2'b01;
            dec.byte_addr  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.alu_ctrl   = alu_add;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec     = '0;
         imm_src = 3'b000;
         use1    = 1'b0;
         use2    = 1'b0;
      end
      // Unused register fields are zeroed so forwarding only reflects real operands.
      dec.rs1 = use1 ? rs1_d : '0;
      dec.rs2 = use2 ? rs2_d : '0;
      dec.rd  = dec.reg_write ? REG_AW'(pif.instr_d[11:7]) : '0;
   end

   always_comb begin
      hazard_raw = 1'b0;
      if (pif.valid_d && e_q.reg_write && e_q.result_src == 2'b01 && e_q.rd != '0)
         hazard_raw = (use1 && rs1_d == e_q.rd) || (use2 && rs2_d == e_q.rd);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q            <= '0;
         reg_write_m_q  <= 1'b0;
         mem_write_m_q  <= 1'b0;
         byte_addr_m_q  <= 1'b0;
         result_src_m_q <= 2'b00;
         rd_m_q         <= '0;
         reg_write_w_q  <= 1'b0;
         result_src_w_q <= 2'b00;
         rd_w_q         <= '0;
      end else if (!pif.stall_ext) begin
         if (pif.flush_e || hazard_raw || !pif.valid_d || !legal)
            e_q <= '0;
         else
            e_q <= dec;
         reg_write_m_q  <= e_q.reg_write;
         mem_write_m_q  <= e_q.mem_write;
         byte_addr_m_q  <= e_q.byte_addr;
         result_src_m_q <= e_q.result_src;
         rd_m_q         <= e_q.rd;
         reg_write_w_q  <= reg_write_m_q;
         result_src_w_q <= result_src_m_q;
         rd_w_q         <= rd_m_q;
      end
   end

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
      if (reg_write_m_q && rd_m_q != '0 && rd_m_q == rs)
         return 2'b10;
      else if (reg_write_w_q && rd_w_q != '0 && rd_w_q == rs)
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign pif.imm_src_d      = pif.valid_d ? imm_src : 3'b000;
   assign pif.illegal_d      = pif.valid_d && !legal;
   assign pif.hazard_stall_d = hazard_raw && !pif.flush_e;
   assign pif.alu_ctrl_e     = e_q.alu_ctrl;
   assign pif.alu_src_e      = e_q.alu_src;
   assign pif.branch_type_e  = e_q.branch_type;
   assign pif.jump_type_e    = e_q.jump_type;
   assign pif.rs1_e          = e_q.rs1;
   assign pif.rs2_e          = e_q.rs2;
   assign pif.rd_e           = e_q.rd;
   assign pif.fwd_a_e        = fwd_sel(e_q.rs1);
   assign pif.fwd_b_e        = fwd_sel(e_q.rs2);
   assign pif.reg_write_m    = reg_write_m_q;
   assign pif.mem_write_m    = mem_write_m_q;
   assign pif.byte_addr_m    = byte_addr_m_q;
   assign pif.result_src_m   = result_src_m_q;
   assign pif.rd_m           = rd_m_q;
   assign pif.reg_write_w    = reg_write_w_q;
   assign pif.result_src_w   = result_src_w_q;
   assign pif.rd_w           = rd_w_q;

endmodule

// File: tb/tb_control_pipe.sv
// tb/tb_control_pipe.sv - scoreboard bench for control_pipe, directed scenarios plus random stream
// Honours CONTROL_PIPE_BRANCH_EXT_EN the same way as the design.
module tb_control_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   control_pipe_if #(.REG_AW(5), .ALUCTRL_W(3)) pif ();
   control_pipe #(.REG_AW(5), .ALUCTRL_W(3)) dut (.clk(clk), .rst(rst), .pif(pif.slave));

   typedef struct packed {
      logic [31:0] w;
      logic        legal;
      logic [2:0]  alu, br, imm;
      logic        asrc, rw, mw, ba, u1, u2;
      logic [1:0]  jmp, rs;
      logic [4:0]  r1, r2, rd;
   } mc_t;

   typedef struct packed {
      logic [2:0] imm_src;
      logic       hz, ill;
      logic [2:0] alu, br;
      logic       asrc;
      logic [1:0] jmp;
      logic [4:0] r1, r2, rd;
      logic [1:0] fa, fb;
      logic       rwm, mwm, bam;
      logic [1:0] rsm;
      logic [4:0] rdm;
      logic       rww;
      logic [1:0] rsw;
      logic [4:0] rdw;
   } exp_t;

   int   checks = 0;
   int   failures = 0;
   exp_t sbq[$];
   mc_t  me, mm, mw, cur_c;
   logic cur_v, cur_f, cur_s;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // Instruction builder: kind selects a mnemonic, result carries encoding and expected controls.
   function automatic mc_t mk(input int kind, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      mc_t         c;
      logic [31:0] r;
      logic [31:0] w;
      r = $urandom;
      c = '0;
      c.legal = 1'b1;
      case (kind)
         0, 1, 2, 3: begin
            c.w   = {(kind == 1) ? 7'h20 : 7'h00, rs2, rs1,
                     (kind == 2) ? 3'b100 : (kind == 3) ? 3'b111 : 3'b000, rd, 7'h33};
            c.alu = (kind == 1) ? 3'd1 : (kind == 2) ? 3'd4 : (kind == 3) ? 3'd2 : 3'd0;
            c.rw = 1; c.u1 = 1; c.u2 = 1;
         end
         4:  begin c.w = {r[11:0], rs1, 3'b000, rd, 7'h13}; c.asrc = 1; c.rw = 1; c.u1 = 1; end
         5, 6, 7, 8, 9, 10: begin
            c.w   = {r[6:0], rs2, rs1, (kind == 5) ? 3'b000 : (kind == 6) ? 3'b001 : 3'(kind - 3), r[11:7], 7'h63};
            c.br  = 3'(kind - 4);
            c.alu = 3'd1; c.imm = 3'd2; c.u1 = 1; c.u2 = 1;
`ifndef CONTROL_PIPE_BRANCH_EXT_EN
            if (kind >= 7) c.legal = 1'b0;
`endif
         end
         11: begin c.w = {r[19:0], rd, 7'h6f}; c.jmp = 2'd1; c.rw = 1; c.rs = 2'd2; c.imm = 3'd3; end
         12: begin c.w = {r[11:0], rs1, 3'b000, rd, 7'h67}; c.jmp = 2'd2; c.rw = 1; c.rs = 2'd2; c.asrc = 1; c.u1 = 1; end
         13: begin c.w = {r[19:0], rd, 7'h37}; c.rw = 1; c.rs = 2'd3; c.imm = 3'd4; end
         14: begin c.w = {r[6:0], rs2, rs1, 3'b000, r[11:7], 7'h23}; c.mw = 1; c.ba = 1; c.asrc = 1; c.imm = 3'd1; c.u1 = 1; c.u2 = 1; end
         15: begin c.w = {r[11:0], rs1, 3'b100, rd, 7'h03}; c.rw = 1; c.rs = 2'd1; c.ba = 1; c.asrc = 1; c.u1 = 1; end
         16: begin c.w = {r[24:0], 7'h7f}; c.legal = 0; end
         17: begin c.w = {7'h00, rs2, rs1, 3'b001, rd, 7'h33}; c.legal = 0; end
         default: begin c.w = {r[11:0], rs1, 3'b010, rd, 7'h03}; c.legal = 0; end
      endcase
      if (!c.legal) begin
         w = c.w;
         c = '0;
         c.w = w;
      end
      c.r1 = c.u1 ? rs1 : 5'd0;
      c.r2 = c.u2 ? rs2 : 5'd0;
      c.rd = c.rw ? rd : 5'd0;
      return c;
   endfunction

   function automatic logic load_use();
      return cur_v && cur_c.legal && me.rw && me.rs == 2'd1 && me.rd != 0 &&
             ((cur_c.u1 && cur_c.r1 == me.rd) || (cur_c.u2 && cur_c.r2 == me.rd));
   endfunction

   function automatic logic [1:0] fwd(input logic [4:0] rs);
      if (mm.rw && mm.rd != 0 && mm.rd == rs) return 2'b10;
      if (mw.rw && mw.rd != 0 && mw.rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic exp_t build_exp();
      exp_t e;
      e.imm_src = (cur_v && cur_c.legal) ? cur_c.imm : 3'd0;
      e.ill = cur_v && !cur_c.legal;
      e.hz  = load_use() && !cur_f;
      e.alu = me.alu; e.br = me.br; e.asrc = me.asrc; e.jmp = me.jmp;
      e.r1 = me.r1; e.r2 = me.r2; e.rd = me.rd;
      e.fa = fwd(me.r1); e.fb = fwd(me.r2);
      e.rwm = mm.rw; e.mwm = mm.mw; e.bam = mm.ba; e.rsm = mm.rs; e.rdm = mm.rd;
      e.rww = mw.rw; e.rsw = mw.rs; e.rdw = mw.rd;
      return e;
   endfunction

   task automatic step(input mc_t c, input logic v, input logic f, input logic s);
      logic lu;
      @(posedge clk);
      #1;
      lu = load_use();
      if (!cur_s) begin
         mw = mm;
         mm = me;
         me = (cur_f || lu || !cur_v || !cur_c.legal) ? mc_t'('0) : cur_c;
      end
      cur_c = c; cur_v = v; cur_f = f; cur_s = s;
      pif.instr_d = c.w; pif.valid_d = v; pif.flush_e = f; pif.stall_ext = s;
      sbq.push_back(build_exp());
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("imm_src_d", pif.imm_src_d, e.imm_src);
         chk("hazard_stall_d", pif.hazard_stall_d, e.hz);
         chk("illegal_d", pif.illegal_d, e.ill);
         chk("alu_ctrl_e", pif.alu_ctrl_e, e.alu);
         chk("alu_src_e", pif.alu_src_e, e.asrc);
         chk("branch_type_e", pif.branch_type_e, e.br);
         chk("jump_type_e", pif.jump_type_e, e.jmp);
         chk("rs1_e", pif.rs1_e, e.r1);
         chk("rs2_e", pif.rs2_e, e.r2);
         chk("rd_e", pif.rd_e, e.rd);
         chk("fwd_a_e", pif.fwd_a_e, e.fa);
         chk("fwd_b_e", pif.fwd_b_e, e.fb);
         chk("reg_write_m", pif.reg_write_m, e.rwm);
         chk("mem_write_m", pif.mem_write_m, e.mwm);
         chk("byte_addr_m", pif.byte_addr_m, e.bam);
         chk("result_src_m", pif.result_src_m, e.rsm);
         chk("rd_m", pif.rd_m, e.rdm);
         chk("reg_write_w", pif.reg_write_w, e.rww);
         chk("result_src_w", pif.result_src_w, e.rsw);
         chk("rd_w", pif.rd_w, e.rdw);
      end
   end

   mc_t nop, c;
   logic hold;

   initial begin
      me = '0; mm = '0; mw = '0; cur_c = '0;
      cur_v = 0; cur_f = 0; cur_s = 0;
      nop = '0;
      pif.instr_d = 32'h0; pif.valid_d = 0; pif.flush_e = 0; pif.stall_ext = 0;
      #3;
      chk("rst_alu_ctrl_e", pif.alu_ctrl_e, 0);
      chk("rst_rd_e", pif.rd_e, 0);
      chk("rst_reg_write_m", pif.reg_write_m, 0);
      chk("rst_rd_w", pif.rd_w, 0);
      chk("rst_hazard", pif.hazard_stall_d, 0);
      @(posedge clk); #1 rst = 0;

      // load-use: lbu x5,0(x1); add x6,x5,x2
      step(mk(15, 5, 1, 0), 1, 0, 0);
      step(mk(0, 6, 5, 2), 1, 0, 0);
      #1 chk("lu_stall", pif.hazard_stall_d, 1);
      step(cur_c, 1, 0, 0);
      #1 chk("lu_bubble_rd_e", pif.rd_e, 0);
      step(nop, 0, 0, 0);
      #1 chk("lu_fwd_a_w", pif.fwd_a_e, 2'b01);

      // back-to-back forwarding: addi x3,x0,1; addi x4,x3,1; add x7,x3,x0
      step(mk(4, 3, 0, 0), 1, 0, 0);
      step(mk(4, 4, 3, 0), 1, 0, 0);
      step(mk(0, 7, 3, 0), 1, 0, 0);
      #1 chk("fw_a_m", pif.fwd_a_e, 2'b10);
      step(nop, 0, 0, 0);
      #1 chk("fw_a_w", pif.fwd_a_e, 2'b01);

      // flush with a load-use present: jal, lbu x5, add x6 under flush
      step(mk(11, 1, 0, 0), 1, 0, 0);
      step(mk(15, 5, 1, 0), 1, 0, 0);
      step(mk(0, 6, 5, 2), 1, 1, 0);
      #1 chk("flush_masks_hz", pif.hazard_stall_d, 0);
      step(nop, 0, 0, 0);
      #1 chk("flush_bubble_alu", pif.jump_type_e, 0);

      // external stall for three cycles mid-stream
      step(mk(4, 1, 2, 0), 1, 0, 0);
      step(mk(0, 2, 1, 1), 1, 0, 0);
      step(mk(14, 0, 2, 1), 1, 0, 0);
      for (int i = 0; i < 3; i++) step(cur_c, 1, 0, 1);
      step(cur_c, 1, 0, 0);
      step(nop, 0, 0, 0);

      // illegal opcode and extended branch
      step(mk(16, 0, 0, 0), 1, 0, 0);
      #1 chk("ill_7f", pif.illegal_d, 1);
      step(mk(7, 0, 1, 2), 1, 0, 0);
      #1 chk("ill_7f_e_zero", pif.alu_src_e | pif.rd_e | pif.alu_ctrl_e, 0);
`ifdef CONTROL_PIPE_BRANCH_EXT_EN
      #1 chk("blt_legal", pif.illegal_d, 0);
      step(nop, 0, 0, 0);
      #1 chk("blt_type_e", pif.branch_type_e, 3'b011);
`else
      #1 chk("blt_illegal", pif.illegal_d, 1);
      step(nop, 0, 0, 0);
      #1 chk("blt_type_e", pif.branch_type_e, 3'b000);
`endif

      // asynchronous reset with a full pipeline
      step(mk(15, 3, 1, 0), 1, 0, 0);
      step(mk(4, 2, 1, 0), 1, 0, 0);
      step(mk(13, 1, 0, 0), 1, 0, 0);
      #1 rst = 1;
      #1;
      chk("arst_rd_e", pif.rd_e, 0);
      chk("arst_rd_m", pif.rd_m, 0);
      chk("arst_reg_write_m", pif.reg_write_m, 0);
      chk("arst_reg_write_w", pif.reg_write_w, 0);
      chk("arst_result_src_w", pif.result_src_w, 0);
      sbq.delete();
      me = '0; mm = '0; mw = '0;
      #1 rst = 0;
      sbq.push_back(build_exp());
      step(mk(0, 4, 1, 2), 1, 0, 0);
      step(nop, 0, 0, 0);
      #1 chk("post_rst_rd_e", pif.rd_e, 4);

      // random stream; D is held while stalled or load-use blocked
      for (int n = 0; n < 500; n++) begin
         hold = cur_s || (load_use() && !cur_f);
         if (hold)
            c = cur_c;
         else
            c = mk($urandom_range(0, 18), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         step(c, hold ? cur_v : ($urandom_range(0, 7) != 0),
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      end

      @(negedge clk);
      #1 chk("sb_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
